// File: rtl/dcc_pkg.sv
// Shared definitions for the DCC packet generator: state encoding, cmd_word
// field offsets and the fixed contents of the idle packet.
package dcc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_START,
    ST_DATA,
    ST_CHECK,
    ST_END
  } dcc_state_e;

  localparam logic [7:0] IDLE_BYTE0 = 8'hFF;
  localparam logic [7:0] IDLE_BYTE1 = 8'h00;
  localparam logic [7:0] IDLE_CHECK = 8'hFF;

  function automatic int len_lsb(input int max_bytes);
    return 8 * max_bytes;
  endfunction

  function automatic int wrap_bit(input int max_bytes);
    return 8 * max_bytes + 3;
  endfunction

  function automatic int rep_lsb(input int max_bytes);
    return 8 * max_bytes + 4;
  endfunction

endpackage

// File: rtl/dcc_bit_timer.sv
// DCC bit timer: each bit is a high half followed by an equal low half whose
// length depends on the bit value; the next bit is sampled on bit_done.
module dcc_bit_timer #(
  parameter int ONE_HALF  = 58,
  parameter int ZERO_HALF = 100
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  input  logic next_bit,
  output logic bit_done,
  output logic track_out
);

  localparam int MAX_HALF = (ONE_HALF > ZERO_HALF) ? ONE_HALF : ZERO_HALF;
  localparam int CW       = $clog2(MAX_HALF + 1);

  logic [CW-1:0] half_cnt;
  logic [CW-1:0] half_last;
  logic          phase;
  logic          cur_bit;

  assign half_last = cur_bit ? CW'(ONE_HALF - 1) : CW'(ZERO_HALF - 1);
  assign bit_done  = run && phase && (half_cnt == half_last);
  // Combinational so that losing run (including an async reset of the
  // controller) drops the track immediately.
  assign track_out = run && !phase;

  // While stopped, keep the first bit preloaded so output starts the cycle run rises.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      half_cnt <= '0;
      phase    <= 1'b0;
      cur_bit  <= 1'b1;
    end else if (!run) begin
      half_cnt <= '0;
      phase    <= 1'b0;
      cur_bit  <= next_bit;
    end else if (half_cnt == half_last) begin
      half_cnt <= '0;
      if (phase) begin
        phase   <= 1'b0;
        cur_bit <= next_bit;
      end else begin
        phase <= 1'b1;
      end
    end else begin
      half_cnt <= half_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dcc_packet_gen.sv
// DCC packet generator: walks the command table and serialises each entry as
// preamble, start-bit-delimited bytes, XOR check byte and end bit.
module dcc_packet_gen
  import dcc_pkg::*;
#(
  parameter  int MAX_BYTES     = 4,
  parameter  int PREAMBLE_BITS = 14,
  parameter  int IDX_W         = 10,
  parameter  int ONE_HALF      = 58,
  parameter  int ZERO_HALF     = 100,
  localparam int CMD_W         = 8 * MAX_BYTES + 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  output logic [IDX_W-1:0] cmd_index,
  input  logic [CMD_W-1:0] cmd_word,
  output logic             track_out,
  output logic             busy,
  output logic             packet_done
);

  localparam int             LEN_LSB  = len_lsb(MAX_BYTES);
  localparam int             WRAP_BIT = wrap_bit(MAX_BYTES);
  localparam int             REP_LSB  = rep_lsb(MAX_BYTES);
  localparam int             PRE_W    = $clog2(PREAMBLE_BITS);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PREAMBLE_BITS - 1);
  localparam logic [2:0]     MAX_LEN  = 3'(MAX_BYTES);

  dcc_state_e state, state_n;

  logic [PRE_W-1:0]       pre_cnt;
  logic [2:0]             bit_cnt;
  logic [2:0]             byte_idx;
  logic [2:0]             pkt_len;
  logic                   pkt_wrap;
  logic [8*MAX_BYTES-1:0] pkt_data;
  logic [7:0]             acc;
  logic [3:0]             rep_cnt;
  logic                   first_send;

  logic                   bit_done;
  logic                   next_bit;
  logic                   run;
  logic                   latch;
  logic                   end_done;
  logic                   byte_last;
  logic [8*MAX_BYTES-1:0] byte_shift;
  logic [7:0]             cur_byte;
  logic [2:0]             nxt_pos;
  logic [2:0]             cmd_len;
  logic [2:0]             load_len;
  logic [8*MAX_BYTES-1:0] load_data;

  assign cmd_len     = cmd_word[LEN_LSB +: 3];
  assign run         = (state != ST_IDLE);
  assign busy        = run;
  assign latch       = (state == ST_PREAMBLE) && bit_done && (pre_cnt == PRE_LAST);
  assign end_done    = (state == ST_END) && bit_done;
  assign packet_done = end_done;
  assign byte_last   = (state == ST_DATA) && bit_done && (bit_cnt == 3'd7);
  assign byte_shift  = pkt_data >> {byte_idx, 3'b000};
  assign cur_byte    = byte_shift[7:0];
  assign nxt_pos     = 3'd6 - bit_cnt;

  // An empty entry becomes a two-byte idle packet; overlong lengths are clamped.
  always_comb begin
    load_data = cmd_word[8*MAX_BYTES-1:0];
    load_len  = cmd_len;
    if (cmd_len == 3'd0) begin
      load_data       = '0;
      load_data[15:0] = {IDLE_BYTE1, IDLE_BYTE0};
      load_len        = 3'd2;
    end else if (cmd_len > MAX_LEN) begin
      load_len = MAX_LEN;
    end
  end

  dcc_bit_timer #(
    .ONE_HALF (ONE_HALF),
    .ZERO_HALF(ZERO_HALF)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .run      (run),
    .next_bit (next_bit),
    .bit_done (bit_done),
    .track_out(track_out)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_n;
  end

  // next_bit is the value of the bit that follows the current one.
  always_comb begin
    state_n  = state;
    next_bit = 1'b1;
    unique case (state)
      ST_IDLE: begin
        if (enable) state_n = ST_PREAMBLE;
      end
      ST_PREAMBLE: begin
        if (latch) begin
          state_n  = ST_START;
          next_bit = 1'b0;
        end
      end
      ST_START: begin
        next_bit = 1'b0;
        if (bit_done) begin
          if (byte_idx == pkt_len) begin
            state_n  = ST_CHECK;
            next_bit = acc[7];
          end else begin
            state_n  = ST_DATA;
            next_bit = cur_byte[7];
          end
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          if (bit_cnt == 3'd7) begin
            state_n  = ST_START;
            next_bit = 1'b0;
          end else begin
            next_bit = cur_byte[nxt_pos];
          end
        end
      end
      ST_CHECK: begin
        if (bit_done) begin
          if (bit_cnt == 3'd7) begin
            state_n  = ST_END;
            next_bit = 1'b1;
          end else begin
            next_bit = acc[nxt_pos];
          end
        end
      end
      ST_END: begin
        if (bit_done) state_n = enable ? ST_PREAMBLE : ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Datapath: counters, packet register, checksum, repeat and index handling.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_index  <= '0;
      pre_cnt    <= '0;
      bit_cnt    <= '0;
      byte_idx   <= '0;
      pkt_len    <= '0;
      pkt_wrap   <= 1'b0;
      pkt_data   <= '0;
      acc        <= '0;
      rep_cnt    <= '0;
      first_send <= 1'b1;
    end else begin
      if ((state == ST_PREAMBLE) && bit_done) begin
        pre_cnt <= latch ? '0 : pre_cnt + 1'b1;
      end
      if (latch) begin
        pkt_data <= load_data;
        pkt_len  <= load_len;
        pkt_wrap <= cmd_word[WRAP_BIT];
        acc      <= '0;
        byte_idx <= '0;
        bit_cnt  <= '0;
        if (first_send) begin
          rep_cnt    <= cmd_word[REP_LSB +: 4];
          first_send <= 1'b0;
        end
      end
      if (((state == ST_DATA) || (state == ST_CHECK)) && bit_done) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (byte_last) begin
        acc      <= acc ^ cur_byte;
        byte_idx <= byte_idx + 1'b1;
      end
      if (end_done) begin
        if (rep_cnt != 4'd0) begin
          rep_cnt <= rep_cnt - 1'b1;
        end else begin
          first_send <= 1'b1;
          cmd_index  <= pkt_wrap ? '0 : cmd_index + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dcc_packet_gen.sv
// Scoreboard bench for dcc_packet_gen: a table model pushes expected packets,
// a track decoder pops and compares them as each packet completes.
module tb_dcc_packet_gen;

  localparam int MAX_BYTES     = 4;
  localparam int PREAMBLE_BITS = 10;
  localparam int IDX_W         = 10;
  localparam int ONE_HALF      = 2;
  localparam int ZERO_HALF     = 4;
  localparam int CMD_W         = 8 * MAX_BYTES + 8;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             enable = 1'b0;
  logic [IDX_W-1:0] cmd_index;
  logic [CMD_W-1:0] cmd_word;
  logic             track_out;
  logic             busy;
  logic             packet_done;

  logic [CMD_W-1:0] tbl [16];

  typedef struct {
    int          idx;
    int          nbytes;
    logic [63:0] bytes;
    int          next_idx;
  } exp_t;

  exp_t expq[$];
  int   n_checks = 0;
  int   n_pass = 0;

  int   model_idx = 0;
  int   model_rep = 0;
  bit   model_first = 1'b1;

  bit   bitq[$];
  int   hi_len = 0;
  int   lo_len = 0;
  bit   in_bit = 1'b0;
  bit   shape_ok = 1'b1;
  bit   idx_pending = 1'b0;
  int   pend_idx = 0;

  dcc_packet_gen #(
    .MAX_BYTES    (MAX_BYTES),
    .PREAMBLE_BITS(PREAMBLE_BITS),
    .IDX_W        (IDX_W),
    .ONE_HALF     (ONE_HALF),
    .ZERO_HALF    (ZERO_HALF)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .cmd_index  (cmd_index),
    .cmd_word   (cmd_word),
    .track_out  (track_out),
    .busy       (busy),
    .packet_done(packet_done)
  );

  assign cmd_word = tbl[cmd_index[3:0]];

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  function automatic logic [CMD_W-1:0] mkEntry(input int len, input int rep, input bit wrap,
                                               input logic [31:0] data);
    return {4'(rep), wrap, 3'(len), data};
  endfunction

  // Walk the table model and push the next n expected packets.
  task automatic applyStimulus(input int n);
    for (int p = 0; p < n; p++) begin
      logic [CMD_W-1:0] ent;
      logic [63:0]      b;
      logic [7:0]       chk;
      int               len;
      int               leff;
      exp_t             e;
      ent = tbl[model_idx[3:0]];
      len = int'(ent[8*MAX_BYTES +: 3]);
      b   = '0;
      chk = '0;
      if (len == 0) begin
        b[15:0] = 16'h00FF;
        leff    = 2;
      end else begin
        leff = (len > MAX_BYTES) ? MAX_BYTES : len;
        for (int k = 0; k < leff; k++) b[8*k +: 8] = ent[8*k +: 8];
      end
      for (int k = 0; k < leff; k++) chk = chk ^ b[8*k +: 8];
      b[8*leff +: 8] = chk;
      e.idx    = model_idx;
      e.nbytes = leff + 1;
      e.bytes  = b;
      if (model_first) begin
        model_rep   = int'(ent[8*MAX_BYTES+4 +: 4]);
        model_first = 1'b0;
      end
      if (model_rep != 0) begin
        model_rep--;
      end else begin
        model_idx   = ent[8*MAX_BYTES+3] ? 0 : (model_idx + 1) % (1 << IDX_W);
        model_first = 1'b1;
      end
      e.next_idx = model_idx;
      expq.push_back(e);
    end
  endtask

  task automatic finalizeBit();
    if ((hi_len == lo_len) && ((hi_len == ONE_HALF) || (hi_len == ZERO_HALF)))
      bitq.push_back(hi_len == ONE_HALF);
    else
      shape_ok = 1'b0;
    hi_len = 0;
    lo_len = 0;
  endtask

  task automatic checkPacket();
    int          i;
    int          pre;
    int          nb;
    bit          end_seen;
    logic [63:0] got;
    logic [7:0]  by;
    exp_t        e;
    i = 0; pre = 0; nb = 0; end_seen = 1'b0; got = '0;
    while (i < bitq.size() && bitq[i]) begin
      pre++;
      i++;
    end
    while (i < bitq.size() && !end_seen) begin
      if (bitq[i]) begin
        end_seen = 1'b1;
        i++;
      end else begin
        i++;
        by = '0;
        for (int k = 0; k < 8; k++) begin
          if (i < bitq.size()) begin
            by = {by[6:0], bitq[i]};
            i++;
          end
        end
        if (nb < 8) got[8*nb +: 8] = by;
        nb++;
      end
    end
    checkOutput("sb_entry_pending", 64'(expq.size() > 0), 64'd1);
    if (expq.size() > 0) begin
      e = expq.pop_front();
      checkOutput("index_during_packet", 64'(cmd_index), 64'(e.idx));
      checkOutput("preamble_len", 64'(pre), 64'(PREAMBLE_BITS));
      checkOutput("byte_count", 64'(nb), 64'(e.nbytes));
      checkOutput("packet_bytes", got, e.bytes);
      checkOutput("end_bit", 64'(end_seen && (i == bitq.size())), 64'd1);
      checkOutput("bit_timing", 64'(shape_ok), 64'd1);
      idx_pending = 1'b1;
      pend_idx    = e.next_idx;
    end
    bitq.delete();
    shape_ok = 1'b1;
  endtask

  // Track decoder: measures each bit's high and low halves at negedge.
  always @(negedge clk) begin
    if (!reset_n) begin
      bitq.delete();
      hi_len      = 0;
      lo_len      = 0;
      in_bit      = 1'b0;
      shape_ok    = 1'b1;
      idx_pending = 1'b0;
    end else begin
      if (idx_pending) begin
        checkOutput("next_index", 64'(cmd_index), 64'(pend_idx));
        idx_pending = 1'b0;
      end
      if (track_out) begin
        if (in_bit && lo_len > 0) finalizeBit();
        hi_len++;
        in_bit = 1'b1;
      end else if (in_bit) begin
        lo_len++;
      end
      if (packet_done) begin
        finalizeBit();
        in_bit = 1'b0;
        checkPacket();
      end
    end
  end

  task automatic waitPackets(input int n, input int budget, input string tag);
    int c;
    for (int p = 0; p < n; p++) begin
      c = 0;
      do begin
        @(negedge clk);
        c++;
      end while (!packet_done && c < budget);
      checkOutput(tag, 64'(packet_done), 64'd1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int c;
    int low_bad;
    for (int k = 0; k < 16; k++) tbl[k] = '0;
    tbl[0] = mkEntry(3, 0, 1'b0, 32'h00103F03);
    tbl[1] = mkEntry(2, 2, 1'b0, 32'h000055AA);
    tbl[2] = mkEntry(0, 0, 1'b0, 32'h00000000);
    tbl[3] = mkEntry(7, 0, 1'b0, 32'h44332211);
    tbl[4] = mkEntry(1, 0, 1'b0, 32'h0000005A);
    tbl[5] = mkEntry(2, 0, 1'b1, 32'h00003412);

    repeat (3) @(negedge clk);
    checkOutput("reset_track", 64'(track_out), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(packet_done), 64'd0);
    checkOutput("reset_index", 64'(cmd_index), 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("idle_track", 64'(track_out), 64'd0);

    $display("[TB] normal, repeat, idle, clamp and wrap packets");
    enable = 1'b1;
    applyStimulus(9);
    #1;
    checkOutput("no_early_track", 64'(track_out), 64'd0);
    @(negedge clk);
    checkOutput("first_bit_latency", 64'(track_out), 64'd1);
    checkOutput("busy_rises", 64'(busy), 64'd1);
    waitPackets(9, 1000, "packet_timeout");

    $display("[TB] enable dropped during data");
    applyStimulus(1);
    repeat (55) @(negedge clk);
    enable = 1'b0;
    waitPackets(1, 1000, "packet_timeout_drop");
    @(negedge clk);
    checkOutput("busy_falls", 64'(busy), 64'd0);
    low_bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (track_out !== 1'b0 || busy !== 1'b0) low_bad++;
    end
    checkOutput("idle_hold", 64'(low_bad), 64'd0);
    checkOutput("index_retained", 64'(cmd_index), 64'(model_idx));
    enable = 1'b1;
    applyStimulus(3);
    waitPackets(3, 1000, "packet_timeout_resume");

    $display("[TB] reset in the middle of a data bit");
    repeat (52) @(negedge clk);
    c = 0;
    while (track_out !== 1'b1 && c < 20) begin
      @(negedge clk);
      c++;
    end
    checkOutput("found_high_half", 64'(track_out), 64'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("reset_track_now", 64'(track_out), 64'd0);
    checkOutput("reset_index_now", 64'(cmd_index), 64'd0);
    checkOutput("reset_busy_now", 64'(busy), 64'd0);
    checkOutput("reset_no_done", 64'(packet_done), 64'd0);
    repeat (3) @(negedge clk);
    reset_n     = 1'b1;
    model_idx   = 0;
    model_rep   = 0;
    model_first = 1'b1;
    applyStimulus(1);
    waitPackets(1, 1000, "packet_timeout_reset");
    repeat (2) @(negedge clk);
    checkOutput("scoreboard_drained", 64'(expq.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dcc_packet_gen.md
# dcc_packet_gen

Parametrised DCC track-signal packet generator that replaces the fixed three-byte generator. It walks a command table through `cmd_index` and serialises each entry as a complete DCC packet: preamble, start-bit-delimited data bytes, XOR error-detect byte and end bit. Packet length, preamble length and bit timing are set by parameters. Each entry carries its own repeat count, and an empty entry sends an idle packet. It sits between the command RAM (read port) and the track driver.

## Interface
Parameters:
- `MAX_BYTES`, 4: maximum data bytes per packet (2..7).
- `PREAMBLE_BITS`, 14: number of preamble '1' bits (≥ 10).
- `IDX_W`, 10: width of `cmd_index`.
- `ONE_HALF`, 58: clk cycles per half-period of a '1' bit (≥ 2).
- `ZERO_HALF`, 100: clk cycles per half-period of a '0' bit (≥ 2).
- Derived `CMD_W` = 8*MAX_BYTES+8.

Ports:
- `clk` in 1: sole clock.
- `reset_n` in 1: reset is asynchronous and active-low.
- `enable` in 1: when high, packets are generated continuously.
- `cmd_index` out IDX_W: command table read address.
- `cmd_word` in CMD_W: table entry at `cmd_index`, with this layout:
  - [8*N-1:0] data bytes, byte 0 in [7:0] and sent first.
  - [8N+2:8N] length L.
  - [8N+3] wrap flag.
  - [8N+7:8N+4] repeat count R.
- `track_out` out 1: encoded DCC signal.
- `busy` out 1: high from leaving IDLE until the end bit completes.
- `packet_done` out 1: one-cycle pulse on the last cycle of each end bit.

## Operation
- Reset values: `cmd_index`=0, `track_out`=0, `busy`=0, `packet_done`=0, repeat counter=0, FSM=IDLE.
- **Bit encoding.** Each bit is a high half followed by a low half of HALF cycles each, with HALF=ONE_HALF or ZERO_HALF. There are no gaps between bits.
  - The timer asserts `bit_done` on the final cycle of every bit.
  - On that same cycle it samples the controller's combinational `next_bit` and starts that bit on the next cycle.
- **FSM states:** IDLE, PREAMBLE, START, DATA, CHECK, END.
  - IDLE: `track_out` held 0. When `enable`=1, go to PREAMBLE on the next cycle; the first bit starts then.
  - PREAMBLE: emit PREAMBLE_BITS '1's.
    - On the last preamble `bit_done`, latch `cmd_word` into the packet register. If this is the first send of the entry, also load the repeat counter with R.
    - Clear the XOR accumulator and go to START.
  - START: emit '0'. Then go to DATA with byte k, or to CHECK once k = L_eff.
  - DATA: emit byte k, MSB first, 8 bits. XOR the byte into the accumulator, k++, then go to START.
  - CHECK: emit the accumulator, MSB first, 8 bits, then go to END.
  - END: emit '1'.
    - On its `bit_done`, pulse `packet_done`.
    - If the repeat counter is ≠ 0, decrement it and keep `cmd_index`.
    - Otherwise set `cmd_index` to 0 if wrap=1, else `cmd_index`+1, which wraps modulo 2^IDX_W.
    - Then go to PREAMBLE if `enable`=1, else IDLE.
- **Length rules.**
  - L=0: send an idle packet. Bytes are 0xFF, 0x00 and the check byte is 0xFF. Repeat count and wrap are honoured as normal.
  - L > MAX_BYTES is clamped to MAX_BYTES.
- Packet length in bits = PREAMBLE_BITS + 9·L_eff + 9 + 1.
- **Enable.** Dropping `enable` mid-packet does not abort the packet. The packet completes through END, then the FSM returns to IDLE. Repeat state and index are retained.
- **Reset mid-packet.** The FSM goes to IDLE asynchronously, `track_out` goes to 0 at once, and no `packet_done` is issued.

## Timing
- Latency from `enable` rising in IDLE to the first `track_out` high: 1 cycle.
- `cmd_index` stays stable for the whole packet and changes only on the END `bit_done` edge. The table therefore has a full preamble to return `cmd_word`, so any read latency < PREAMBLE_BITS·2·ONE_HALF cycles is tolerated.
- `cmd_word` is sampled on exactly one cycle: the last preamble `bit_done`. It is ignored at all other times.
- `busy` falls on the cycle after `packet_done` when going to IDLE. It stays high when going back to PREAMBLE.

## Structure
- **Shared package `dcc_pkg`:**
  - State encoding.
  - Field offset functions for the `cmd_word` layout, based on MAX_BYTES.
  - Idle-packet constants: 0xFF, 0x00 and check byte 0xFF.
- **Sub-module `dcc_bit_timer`**, parameters ONE_HALF and ZERO_HALF.
  - Inputs: `clk`, `reset_n`, `run`, `next_bit`.
  - Outputs: `bit_done`, `track_out`.
  - Internals: half-period counter and phase flag.
- **Top level:** FSM, packet register, byte/bit counters, XOR accumulator, repeat counter, index logic.

## Test plan
Bench parameters: ONE_HALF=2, ZERO_HALF=4, PREAMBLE_BITS=10.
- **Normal packet.** Entry 0: L=3, bytes 0x03, 0x3F, 0x10, R=0, wrap=0.
  - Expect 10 ones, then 0,0x03, 0,0x3F, 0,0x10, 0,0x2C, then 1.
  - Expect `packet_done` once and `cmd_index`=1.
  - Each '1' lasts 4 cycles and each '0' lasts 8 cycles.
- **Repeat count.** Entry with R=2: sent 3 identical times with `cmd_index` unchanged, then advances after the third `packet_done`.
- **Wrap flag.** Entry 5 with wrap=1: after its packet, `cmd_index`=0 and entry 0 is sent next.
- **Empty entry.** L=0: decoded bytes are 0xFF, 0x00 and check byte 0xFF. L=7 with MAX_BYTES=4 sends exactly 4 data bytes.
- **Enable drop.** Drop `enable` during DATA: the packet completes with the end bit, then `busy`=0 and `track_out` is held 0. Re-raising `enable` resumes at the next `cmd_index`.
- **Reset mid-packet.** Assert `reset_n`=0 during the high half of a data bit: `track_out` goes to 0 in the same cycle and `cmd_index`=0. After release, a fresh preamble starts from entry 0.
